// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and helpers for the pc_seq program counter.
//                - op_t      : the single action taken by pc_seq in a cycle
//                - decode_op : strobe vector -> op_t, in priority order
//                - ras_ptr_w : stack-pointer width for a given RAS depth
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_RET  = 3'd1,
        OP_CALL = 3'd2,
        OP_LOAD = 3'd3,
        OP_BR   = 3'd4,
        OP_INC  = 3'd5
    } op_t;

    // Strobe vector layout: {stall, ret, call, load, branch, inc}.
    // Priority: stall > ret > call > load > branch > inc > hold.
    // Stall maps to OP_HOLD so that nothing downstream moves.
    function automatic op_t decode_op(input logic [5:0] strobes);
        op_t op;
        op = OP_HOLD;
        if (strobes[5])      op = OP_HOLD;
        else if (strobes[4]) op = OP_RET;
        else if (strobes[3]) op = OP_CALL;
        else if (strobes[2]) op = OP_LOAD;
        else if (strobes[1]) op = OP_BR;
        else if (strobes[0]) op = OP_INC;
        return op;
    endfunction

    // Stack-pointer width for a power-of-two depth.
    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_if
//  Description : Control/status bundle between the controller and pc_seq.
//                Strobes : stall, inc, load, branch, call, ret
//                Data in : load_addr, br_off
//                Status  : pc, ras_empty, ras_full, ras_ovf, ras_unf
//                modport master : controller side (drives strobes)
//                modport slave  : pc_seq side (drives pc and flags)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_seq_if #(
    parameter int AW = 16
);
    logic          stall;
    logic          inc;
    logic          load;
    logic [AW-1:0] load_addr;
    logic          branch;
    logic [AW-1:0] br_off;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    modport master (
        output stall, inc, load, load_addr, branch, br_off, call, ret,
        input  pc, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, inc, load, load_addr, branch, br_off, call, ret,
        output pc, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras
//  Description : Circular return-address stack (LIFO).
//                Ports: clk, rst       - clock, sync active-high reset
//                       push, pop      - one-cycle strobes (pop wins)
//                       push_data      - address to push
//                       top_data       - most recently pushed entry
//                       empty, full    - count == 0 / count == RAS_DEPTH
//                       ovf, unf       - sticky: push while full / pop while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int AW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic [AW-1:0] push_data,
    output logic      [AW-1:0] top_data,
    output logic               empty,
    output logic               full,
    output logic               ovf,
    output logic               unf
);
    localparam int PW = ras_ptr_w(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(RAS_DEPTH);

    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] r_sp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_empty;
    logic          w_full;
    logic          w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);
    // Pop has priority so a simultaneous strobe never corrupts the stack.
    assign w_push  = push && !pop;

    // Entry storage carries no reset: contents are meaningless once count=0.
    // Pointer wraps naturally because RAS_DEPTH is a power of two, so a push
    // while full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_sp] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (pop) begin
            if (w_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_sp    <= r_sp - PW'(1);
                r_count <= r_count - CW'(1);
            end
        end else if (w_push) begin
            r_sp <= r_sp + PW'(1);
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign top_data = r_mem[r_sp - PW'(1)];
    assign empty    = w_empty;
    assign full     = w_full;
    assign ovf      = r_ovf;
    assign unf      = r_unf;

endmodule
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq
//  Description : Parametrised program counter with increment, absolute load,
//                relative branch, stall, and call/return via a circular RAS.
//                Ports: clk  - system clock
//                       rst  - synchronous active-high reset
//                       bus  - pc_seq_if.slave (strobes in, pc/flags out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int              AW        = 16,
    parameter int              INC_STEP  = 1,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_seq_if.slave   bus
);
    localparam logic [AW-1:0] C_STEP = AW'(INC_STEP);

    logic [AW-1:0] r_pc;

    op_t           w_op;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_pc_br;
    logic [AW-1:0] w_ras_top;
    logic          w_ras_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_pc_next;

    assign w_op = decode_op({bus.stall, bus.ret, bus.call,
                             bus.load, bus.branch, bus.inc});

    // Both sums wrap modulo 2^AW; br_off is already AW bits wide, so adding
    // it directly is the sign-extended relative jump.
    assign w_pc_inc = r_pc + C_STEP;
    assign w_pc_br  = r_pc + bus.br_off;

    assign w_push = (w_op == OP_CALL);
    assign w_pop  = (w_op == OP_RET);

    always_comb begin
        w_pc_next = r_pc;
        case (w_op)
            // A ret on an empty stack falls through to the next instruction.
            OP_RET:  w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
            OP_CALL: w_pc_next = bus.load_addr;
            OP_LOAD: w_pc_next = bus.load_addr;
            OP_BR:   w_pc_next = w_pc_br;
            OP_INC:  w_pc_next = w_pc_inc;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    pc_ras #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_ras_top),
        .empty     (w_ras_empty),
        .full      (bus.ras_full),
        .ovf       (bus.ras_ovf),
        .unf       (bus.ras_unf)
    );

    assign bus.pc        = r_pc;
    assign bus.ras_empty = w_ras_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_seq
//  Description : Self-checking bench for pc_seq. A queue-based reference
//                model (bounded LIFO that drops its oldest entry) tracks pc and
//                flags; directed steps are followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq;
    localparam int            AW        = 16;
    localparam int            STEP      = 1;
    localparam logic [15:0]   RV        = 16'h0100;
    localparam int            DEPTH     = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_seq_if #(.AW(AW)) bus ();

    pc_seq #(
        .AW        (AW),
        .INC_STEP  (STEP),
        .RESET_VEC (RV),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack [$];
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    32'(bus.pc), 32'(m_pc));
        check({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_stack.size() == 0));
        check({tag, ".full"},  32'(bus.ras_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".ovf"},   32'(bus.ras_ovf), 32'(m_ovf));
        check({tag, ".unf"},   32'(bus.ras_unf), 32'(m_unf));
    endtask

    // Apply one cycle of stimulus, advance the model by the same rules, then
    // compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic s,
                       input logic rt, input logic c, input logic l,
                       input logic b, input logic i,
                       input logic [AW-1:0] la, input logic [AW-1:0] bo);
        rst = r; bus.stall = s; bus.ret = rt; bus.call = c; bus.load = l;
        bus.branch = b; bus.inc = i; bus.load_addr = la; bus.br_off = bo;
        if (r) begin
            m_pc = RV; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (s) begin
            // nothing moves
        end else if (rt) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = m_pc + AW'(STEP); m_unf = 1'b1; end
        end else if (c) begin
            if (m_stack.size() == DEPTH) begin
                void'(m_stack.pop_front());
                m_ovf = 1'b1;
            end
            m_stack.push_back(m_pc + AW'(STEP));
            m_pc = la;
        end else if (l) m_pc = la;
        else if (b)     m_pc = m_pc + bo;
        else if (i)     m_pc = m_pc + AW'(STEP);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        total = 0; bad = 0;
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        rst = 1'b1; bus.stall = 0; bus.ret = 0; bus.call = 0; bus.load = 0;
        bus.branch = 0; bus.inc = 0; bus.load_addr = '0; bus.br_off = '0;
        @(posedge clk); #1;

        // 1. reset + increments            r  s  rt c  l  b  i
        cyc("reset",  1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
        check("reset.pc_const", 32'(bus.pc), 32'h0100);
        cyc("inc1",   0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        cyc("inc2",   0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        cyc("inc3",   0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("inc3.pc_const", 32'(bus.pc), 32'h0103);

        // 2. branch backwards to zero, then inc wrap
        cyc("ld10",   0, 0, 0, 0, 1, 0, 0, 16'h0010, 16'h0);
        cyc("brneg",  0, 0, 0, 0, 0, 1, 0, 16'h0, 16'hFFF0);
        check("brneg.pc_const", 32'(bus.pc), 32'h0000);
        cyc("ldFFFF", 0, 0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0);
        cyc("incwrap",0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
        check("incwrap.pc_const", 32'(bus.pc), 32'h0000);
        cyc("brm1",   0, 0, 0, 0, 0, 1, 0, 16'h0, 16'hFFFF);

        // 3. nested call/return
        cyc("ld20",   0, 0, 0, 0, 1, 0, 0, 16'h0020, 16'h0);
        cyc("call1",  0, 0, 0, 1, 0, 0, 0, 16'h0100, 16'h0);
        cyc("call2",  0, 0, 0, 1, 0, 0, 0, 16'h0200, 16'h0);
        cyc("ret1",   0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("ret1.pc_const", 32'(bus.pc), 32'h0101);
        cyc("ret2",   0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("ret2.pc_const", 32'(bus.pc), 32'h0021);

        // 4. overflow: five calls from 0x10..0x14, each to pc+1
        cyc("ld10b",  0, 0, 0, 0, 1, 0, 0, 16'h0010, 16'h0);
        for (int k = 0; k < 5; k++)
            cyc("ovcall", 0, 0, 0, 1, 0, 0, 0, 16'h0011 + 16'(k), 16'h0);
        check("ovf.const", 32'(bus.ras_ovf), 32'h1);
        for (int k = 0; k < 4; k++) begin
            cyc("ovret", 0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
            check("ovret.pc_const", 32'(bus.pc), 32'h0015 - 32'(k));
        end

        // 5. underflow
        cyc("ld40",   0, 0, 0, 0, 1, 0, 0, 16'h0040, 16'h0);
        cyc("unf",    0, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
        check("unf.pc_const", 32'(bus.pc), 32'h0041);
        cyc("unfhold",0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);

        // 6. priority and stall
        cyc("push",   0, 0, 0, 1, 0, 0, 0, 16'h0300, 16'h0);
        cyc("stall",  0, 1, 1, 1, 1, 1, 1, 16'h0555, 16'h0004);
        cyc("prio",   0, 0, 1, 1, 1, 0, 1, 16'h0777, 16'h0);
        check("prio.pc_const", 32'(bus.pc), 32'h0043);
        cyc("push2",  0, 0, 0, 1, 0, 0, 0, 16'h0400, 16'h0);
        cyc("rststl", 1, 1, 0, 0, 0, 0, 1, 16'h0, 16'h0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            cyc("rand",
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 1) == 0),
                16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program counter, successor to the 16-bit load/increment PC. Adds relative branch, configurable increment step, stall, and call/return through an internal circular return-address stack (RAS). Drives the current instruction address to the bus and memory address path. Takes its control strobes from the controller.

Parameters:
AW, 16, address width in bits (≥8).
INC_STEP, 1, amount added per increment (1..2^AW-1).
RESET_VEC, 0, value loaded into pc on reset (AW bits).
RAS_DEPTH, 4, number of return-address entries (power of 2, ≥2).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  hold pc and RAS unchanged this cycle.
inc  in  1  pc <= pc + INC_STEP.
load  in  1  absolute jump: pc <= load_addr.
load_addr  in  AW  absolute target for load and call.
branch  in  1  relative jump: pc <= pc + sext(br_off).
br_off  in  AW  two's-complement offset, relative to current pc.
call  in  1  push pc+INC_STEP onto RAS; pc <= load_addr.
ret  in  1  pop RAS into pc.
pc  out  AW  current address (registered).
ras_empty  out  1  RAS count == 0.
ras_full  out  1  RAS count == RAS_DEPTH.
ras_ovf  out  1  sticky: call issued while full.
ras_unf  out  1  sticky: ret issued while empty.

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_VEC, RAS count=0, stack pointer=0, ras_ovf=0, ras_unf=0. Reset overrides every other input. RAS entry contents are don't-care after reset.
- Priority, evaluated each posedge with rst=0: stall > ret > call > load > branch > inc > hold. Exactly one action per cycle; lower-priority strobes asserted in the same cycle are ignored.
- Latency: 1 cycle. pc reflects the action at the posedge following strobe sampling. Flags are combinational from registered state only; they are valid in the cycle after the update.
- stall: pc, RAS, and sticky flags all unchanged, including pending ret or call.
- Arithmetic: all pc sums are modulo 2^AW.
  - pc=2^AW-1 with inc (step 1) gives 0.
  - A branch offset of all-ones is -1.
- call: entry[sp] <= pc+INC_STEP (mod 2^AW); sp <= sp+1 (mod RAS_DEPTH); count <= min(count+1, RAS_DEPTH); pc <= load_addr.
  - When full, the push overwrites the oldest entry (circular) and sets ras_ovf. Count stays RAS_DEPTH.
- ret: when count>0, pc <= entry[sp-1]; sp <= sp-1; count <= count-1.
  - When count==0, pc <= pc+INC_STEP, sp and count are unchanged, and ras_unf is set.
- Sticky flags clear only on rst.
- ret and call in the same cycle: ret wins and call is dropped. Controller must not issue both.
- Reset mid-sequence (for example, during nested calls) discards the entire stack.

Decomposition:
- Shared package pc_seq_pkg:
  - op enum: OP_HOLD, OP_RET, OP_CALL, OP_LOAD, OP_BR, OP_INC.
  - Function decoding the strobe vector {stall, ret, call, load, branch, inc} to op per the priority above.
  - Constant helper for log2(RAS_DEPTH).
- Sub-module pc_ras: circular LIFO.
  - Parameters AW and RAS_DEPTH.
  - Ports clk, rst, push, pop, push_data, top_data, empty, full, ovf, unf.
  - Holds the entry array, sp, and count.
- pc_seq contains the pc register, next-pc mux and adders, and one pc_ras instance.

Test Plan:
1. Reset and increment: assert rst with RESET_VEC=0x0100, then 3 cycles with inc=1 → pc = 0x0100, 0x0101, 0x0102, 0x0103. Flags: ras_empty=1, ras_ovf=0, ras_unf=0.
2. Branch and wrap: from pc=0x0010, branch with br_off=0xFFF0 → pc=0x0000. Then load 0xFFFF and inc → pc=0x0000.
3. Nested call/return: at pc=0x0020, call to 0x0100; at 0x0100, call to 0x0200. Two rets → pc=0x0101, then 0x0021, and ras_empty=1.
4. Overflow: 5 calls from pcs 0x10..0x14 (DEPTH=4) → ras_ovf=1, ras_full=1. Four rets → 0x15, 0x14, 0x13, 0x12 (oldest entry 0x11 lost).
5. Underflow: ret with RAS empty at pc=0x0040 → pc=0x0041, ras_unf=1. ras_unf stays 1 until rst.
6. Priority and stall:
   - All strobes high with stall=1 → pc and RAS unchanged.
   - ret+call+load+inc with stall=0 and a non-empty RAS → pc = top entry, count decremented by 1, no push.
   - rst asserted during a stall → pc=RESET_VEC.
